// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 pipelined bus bundle for the word-organised RAM responder.
// Signal names keep the responder-side _i/_o suffixes of the original port list.
interface wb_ram_slave_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        err_o;
   logic        stall_o;

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      output dat_o, ack_o, err_o, stall_o
   );

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      input  dat_o, ack_o, err_o, stall_o
   );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B4 RAM responder: byte-lane writes, programmable wait states,
// and error termination for addresses outside the mapped window.
module wb_ram_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          rst,
   wb_ram_slave_if.slave wb
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
   localparam bit          NO_WAIT  = (WAIT_STATES == 0);
   localparam logic [3:0]  CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

   logic [31:0]   mem [DEPTH_WORDS];

   state_t        state;
   logic [3:0]    cnt;
   logic          we_q;
   logic [31:0]   wdat_q;
   logic [3:0]    sel_q;
   logic [AW-1:0] idx_q;
   logic          in_range_q;
   logic          ack_q;
   logic          err_q;
   logic          stall_q;
   logic [31:0]   rdata_q;

   logic [31:0]   off;
   logic          req_in_range;
   logic [AW-1:0] req_idx;
   logic          req;

   always_comb begin
      off          = wb.adr_i - BASE_ADDR;
      req_in_range = (wb.adr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
      req_idx      = off[AW+1:2];
      req          = wb.cyc_i & wb.stb_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         wdat_q     <= '0;
         sel_q      <= '0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         stall_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               if (req) begin
                  we_q       <= wb.we_i;
                  wdat_q     <= wb.dat_i;
                  sel_q      <= wb.sel_i;
                  idx_q      <= req_idx;
                  in_range_q <= req_in_range;
                  stall_q    <= 1'b1;
                  if (NO_WAIT) begin
                     // Zero-wait path reads straight from the incoming index.
                     state   <= S_RESP;
                     ack_q   <= req_in_range;
                     err_q   <= ~req_in_range;
                     rdata_q <= req_in_range ? mem[req_idx] : '0;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (!wb.cyc_i) begin
                  state <= S_DONE;
               end else if (cnt == '0) begin
                  state   <= S_RESP;
                  ack_q   <= in_range_q;
                  err_q   <= ~in_range_q;
                  rdata_q <= in_range_q ? mem[idx_q] : '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state   <= S_DONE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            S_DONE: begin
               state   <= S_IDLE;
               stall_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write commits on the edge leaving RESP so an abort in RESP drops it.
   always_ff @(posedge clk) begin
      if (state == S_RESP && wb.cyc_i && we_q && in_range_q) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
         end
      end
   end

   assign wb.ack_o   = ack_q & wb.cyc_i;
   assign wb.err_o   = err_q & wb.cyc_i;
   assign wb.stall_o = stall_q;
   assign wb.dat_o   = rdata_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances with different wait/base settings,
// checked against an address-keyed memory model built from the bus rules.
module tb_wb_ram_slave;

   localparam int unsigned WS0 = 1, WS1 = 0, WS2 = 3;
   localparam logic [31:0] B0 = 32'h0, B1 = 32'h1000, B2 = 32'h0;
   localparam int unsigned D0 = 1024, D1 = 1024, D2 = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        cyc [3];
   logic        stb [3];
   logic        we  [3];
   logic [31:0] adr [3];
   logic [31:0] wdat[3];
   logic [3:0]  sel [3];
   logic        ack [3];
   logic        err [3];
   logic        stall[3];
   logic [31:0] rdat[3];

   wb_ram_slave_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_conn
      assign bus[g].cyc_i = cyc[g];
      assign bus[g].stb_i = stb[g];
      assign bus[g].we_i  = we[g];
      assign bus[g].adr_i = adr[g];
      assign bus[g].dat_i = wdat[g];
      assign bus[g].sel_i = sel[g];
      assign ack[g]   = bus[g].ack_o;
      assign err[g]   = bus[g].err_o;
      assign stall[g] = bus[g].stall_o;
      assign rdat[g]  = bus[g].dat_o;
   end

   wb_ram_slave #(.DEPTH_WORDS(D0), .BASE_ADDR(B0), .WAIT_STATES(WS0)) dut0 (.clk(clk), .rst(rst), .wb(bus[0]));
   wb_ram_slave #(.DEPTH_WORDS(D1), .BASE_ADDR(B1), .WAIT_STATES(WS1)) dut1 (.clk(clk), .rst(rst), .wb(bus[1]));
   wb_ram_slave #(.DEPTH_WORDS(D2), .BASE_ADDR(B2), .WAIT_STATES(WS2)) dut2 (.clk(clk), .rst(rst), .wb(bus[2]));

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   logic [31:0] mdl [longint unsigned];

   function automatic int unsigned ws_of(input int k);
      return (k == 0) ? WS0 : (k == 1) ? WS1 : WS2;
   endfunction
   function automatic longint base_of(input int k);
      return (k == 0) ? longint'(B0) : (k == 1) ? longint'(B1) : longint'(B2);
   endfunction
   function automatic longint depth_of(input int k);
      return (k == 0) ? longint'(D0) : (k == 1) ? longint'(D1) : longint'(D2);
   endfunction
   function automatic longint unsigned key_of(input int k, input logic [31:0] a);
      return (longint'(k) << 32) | longint'(a >> 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One complete Wishbone access plus model update and checks.
   task automatic txn(input int k, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input string tag);
      int lat, stall_n, guard;
      bit inr;
      longint unsigned key;
      logic [31:0] m;
      inr = (longint'(a) >= base_of(k)) && (longint'(a) - base_of(k) < depth_of(k) * 4);
      key = key_of(k, a);
      @(negedge clk);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = s;
      @(posedge clk);
      #1 stb[k] = 1'b0;
      lat = 0; stall_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (stall[k]) stall_n++;
      end while (!ack[k] && !err[k] && lat < 40);
      chk({tag, "_lat"}, lat, ws_of(k) + 1);
      chk({tag, "_ack"}, ack[k], inr);
      chk({tag, "_err"}, err[k], !inr);
      if (!w) begin
         if (!inr) chk({tag, "_rdat_oor"}, rdat[k], 32'h0);
         else if (mdl.exists(key)) chk({tag, "_rdat"}, rdat[k], mdl[key]);
      end
      @(posedge clk);
      #1 cyc[k] = 1'b0;
      @(negedge clk);
      if (stall[k]) stall_n++;
      chk({tag, "_term_pulse"}, ack[k] | err[k], 1'b0);
      guard = 0;
      while (stall[k] && guard < 10) begin
         @(negedge clk);
         guard++;
         if (stall[k]) stall_n++;
      end
      chk({tag, "_stall_cycles"}, stall_n, ws_of(k) + 2);
      if (w && inr) begin
         if (mdl.exists(key) || s == 4'hF) begin
            m = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
            mdl[key] = m;
         end else begin
            mdl.delete(key);
         end
      end
   endtask

   initial begin
      int n;
      bit saw;
      logic [31:0] a;
      logic [3:0] s;
      bit w;
      for (int k = 0; k < 3; k++) begin
         cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = '0; wdat[k] = '0; sel[k] = '0;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_stall", stall[k], 1'b0);
         chk("rst_ack", ack[k], 1'b0);
         chk("rst_err", err[k], 1'b0);
         chk("rst_dat", rdat[k], 32'h0);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic write/readback, one wait state.
      txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
      txn(0, 0, 32'h10, 32'h0, 4'hF, "rd10");
      chk("rd10_const", mdl[key_of(0, 32'h10)], 32'hDEADBEEF);

      // Byte lanes.
      txn(0, 1, 32'h20, 32'h11223344, 4'hF, "pre20");
      txn(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, "lane20");
      txn(0, 0, 32'h20, 32'h0, 4'h0, "rd20");
      chk("lane20_const", mdl[key_of(0, 32'h20)], 32'h11BB33DD);
      txn(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, "sel0");
      txn(0, 0, 32'h20, 32'h0, 4'hF, "rd20b");

      // Range checks on the offset window.
      txn(1, 1, 32'h1FFC, 32'h600DCAFE, 4'hF, "pre1ffc");
      txn(1, 0, 32'h2000, 32'h0, 4'hF, "rd2000");
      txn(1, 1, 32'h0FFC, 32'h12345678, 4'hF, "wr0ffc");
      txn(1, 0, 32'h1FFC, 32'h0, 4'hF, "rd1ffc");
      txn(1, 0, 32'h1000, 32'h0, 4'hF, "rd1000");

      // Zero-wait back-to-back reads with strobe held.
      txn(1, 1, 32'h1040, 32'hA5A5_0F0F, 4'hF, "pre1040");
      @(negedge clk);
      cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h1040; sel[1] = 4'hF;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         chk("b2b_ack", ack[1], (i % 3) == 1);
         chk("b2b_stall", stall[1], (i % 3) != 0);
         if (ack[1]) chk("b2b_dat", rdat[1], mdl[key_of(1, 32'h1040)]);
      end
      cyc[1] = 0; stb[1] = 0;
      repeat (3) @(negedge clk);

      // Abort during wait states.
      txn(2, 1, 32'h4, 32'h0BAD_F00D, 4'hF, "pre4");
      @(negedge clk);
      cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h4; wdat[2] = 32'h55; sel[2] = 4'hF;
      @(posedge clk);
      saw = 0;
      repeat (2) begin
         @(negedge clk);
         if (ack[2] || err[2]) saw = 1;
      end
      cyc[2] = 0; stb[2] = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (ack[2] || err[2]) saw = 1;
         if (i == 1) chk("abort_stall_hold", stall[2], 1'b1);
         if (i == 2) chk("abort_stall_rel", stall[2], 1'b0);
      end
      chk("abort_no_term", saw, 1'b0);
      txn(2, 0, 32'h4, 32'h0, 4'hF, "abort_rd4");

      // Reset in the middle of a write.
      txn(2, 1, 32'h8, 32'hCAFE_F00D, 4'hF, "pre8");
      @(negedge clk);
      cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h8; wdat[2] = 32'h1234_5678; sel[2] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      chk("mid_stall", stall[2], 1'b1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_stall", stall[2], 1'b0);
      chk("mid_rst_ack", ack[2], 1'b0);
      chk("mid_rst_err", err[2], 1'b0);
      @(negedge clk);
      cyc[2] = 0; stb[2] = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      txn(2, 0, 32'h8, 32'h0, 4'hF, "rst_rd8");

      // Randomised accesses on the two faster instances.
      for (int i = 0; i < 30; i++) begin
         n = (i % 2);
         w = $urandom_range(0, 1);
         s = 4'($urandom_range(0, 15));
         if (n == 0) a = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 15)) * 4
                                                    : 32'($urandom_range(0, 15)) * 4;
         else a = 32'h1000 - 32'h20 + 32'($urandom_range(0, 23)) * 4 + ((($urandom_range(0, 3) == 0)) ? 32'h1000 : 32'h0);
         a = a | 32'($urandom_range(0, 3));
         txn(n, w, a, $urandom, s, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
